// File: rtl/mem_access_unit_if.sv
// Shared types for the MEM stage and the data-bus interface it masters.
// The package comes first so the access-type enum is visible to the bus
// interface, the MEM stage and the testbench alike.

package mem_access_unit_pkg;

    localparam int MEM_ACCESS_TYPE_WIDTH = 3;

    // Bit 2 marks a write; bits [1:0] give the size (0 means no memory access).
    typedef enum logic [MEM_ACCESS_TYPE_WIDTH-1:0] {
        ACC_NONE       = 3'b000,
        ACC_READ_BYTE  = 3'b001,
        ACC_READ_HALF  = 3'b010,
        ACC_READ_WORD  = 3'b011,
        ACC_WRITE_BYTE = 3'b101,
        ACC_WRITE_HALF = 3'b110,
        ACC_WRITE_WORD = 3'b111
    } access_type_e;

    localparam logic [1:0] EXC_NONE       = 2'b00;
    localparam logic [1:0] EXC_MISALIGNED = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT    = 2'b10;

endpackage

// Data-bus signals between the MEM stage (master) and data memory (slave).
interface mem_access_unit_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ready, rdata);
    modport slave  (input req, we, addr, be, wdata, output ready, rdata);

endinterface

// File: rtl/mem_access_unit.sv
// MEM stage of the 5-stage core. Runs one data-bus transaction per aligned
// load/store, stalls upstream while it is outstanding, and hands fully
// aligned and extended load data to the MEM/WB register.

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  access_type_e         ex_access_type,
    input  logic                 ex_sign_ext,
    input  logic [31:0]          ex_addr,
    input  logic [31:0]          ex_wdata,
    input  logic [4:0]           ex_rd_addr,
    input  logic                 ex_reg_wen,
    input  logic                 flush,
    output logic                 mem_stall,
    mem_access_unit_if.master    bus,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd_addr,
    output logic                 wb_reg_wen,
    output logic [31:0]          wb_data,
    output logic [1:0]           wb_exc
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic {S_IDLE, S_BUS} state_e;

    state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Operation latched on acceptance, needed once the bus answers.
    logic        op_write, op_sign, op_wen;
    logic [1:0]  op_size, op_off;
    logic [4:0]  op_rd;

    // Bus attributes held stable for the whole transaction.
    logic        bus_we_q;
    logic [31:0] bus_addr_q, bus_wdata_q;
    logic [3:0]  bus_be_q;

    logic        accept, leave_bus, bus_req_c;
    logic [1:0]  ex_size;
    logic        ex_misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    logic        wb_valid_nxt, wb_reg_wen_nxt;
    logic [4:0]  wb_rd_addr_nxt;
    logic [31:0] wb_data_nxt;
    logic [1:0]  wb_exc_nxt;

    assign ex_size       = ex_access_type[1:0];
    assign ex_misaligned = (ex_size == 2'd2 && ex_addr[0]) ||
                           (ex_size == 2'd3 && ex_addr[1:0] != 2'b00);

    assign bus.req   = bus_req_c;
    assign bus.we    = bus_we_q;
    assign bus.addr  = bus_addr_q;
    assign bus.be    = bus_be_q;
    assign bus.wdata = bus_wdata_q;

    // Store lane steering: replicate data so every lane carries the payload.
    always_comb begin
        // NOTE: every combinationally written signal gets a default first so no latch is inferred.
        st_be    = 4'b0000;
        st_wdata = 32'h0;
        if (ex_access_type[2]) begin
            case (ex_size)
                2'd1: begin
                    st_be    = 4'b0001 << ex_addr[1:0];
                    st_wdata = {4{ex_wdata[7:0]}};
                end
                2'd2: begin
                    st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{ex_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = ex_wdata;
                end
            endcase
        end
    end

    // Load lane extraction and sign/zero extension.
    always_comb begin
        case (op_off)
            2'd0:    ld_byte = bus.rdata[7:0];
            2'd1:    ld_byte = bus.rdata[15:8];
            2'd2:    ld_byte = bus.rdata[23:16];
            default: ld_byte = bus.rdata[31:24];
        endcase
        ld_half = op_off[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (op_size)
            2'd1:    ld_data = {{24{op_sign & ld_byte[7]}}, ld_byte};
            2'd2:    ld_data = {{16{op_sign & ld_half[15]}}, ld_half};
            default: ld_data = bus.rdata;
        endcase
    end

    // Next-state, stall, bus request and MEM/WB next values.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        mem_stall      = 1'b0;
        bus_req_c      = 1'b0;
        accept         = 1'b0;
        leave_bus      = 1'b0;
        wb_valid_nxt   = 1'b0;
        wb_rd_addr_nxt = 5'd0;
        wb_reg_wen_nxt = 1'b0;
        wb_data_nxt    = 32'h0;
        wb_exc_nxt     = EXC_NONE;
        case (state)
            S_IDLE: begin
                if (ex_valid && !flush) begin
                    wb_rd_addr_nxt = ex_rd_addr;
                    if (ex_size == 2'd0) begin
                        wb_valid_nxt   = 1'b1;
                        wb_reg_wen_nxt = ex_reg_wen;
                        wb_data_nxt    = ex_addr;
                    end else if (ex_misaligned) begin
                        wb_valid_nxt = 1'b1;
                        wb_data_nxt  = ex_addr;
                        wb_exc_nxt   = EXC_MISALIGNED;
                    end else begin
                        mem_stall = 1'b1;
                        accept    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_BUS;
                    end
                end
            end
            S_BUS: begin
                wb_rd_addr_nxt = op_rd;
                if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT)) begin
                    leave_bus    = 1'b1;
                    state_nxt    = S_IDLE;
                    wb_valid_nxt = 1'b1;
                    wb_data_nxt  = bus_addr_q;
                    wb_exc_nxt   = EXC_TIMEOUT;
                end else begin
                    bus_req_c = 1'b1;
                    mem_stall = ~bus.ready;
                    if (bus.ready) begin
                        leave_bus      = 1'b1;
                        state_nxt      = S_IDLE;
                        wb_valid_nxt   = 1'b1;
                        wb_reg_wen_nxt = op_wen & ~op_write;
                        wb_data_nxt    = op_write ? 32'h0 : ld_data;
                    end else if (TIMEOUT != 0) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Latched op, held bus attributes and the MEM/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write    <= 1'b0;
            op_sign     <= 1'b0;
            op_wen      <= 1'b0;
            op_size     <= 2'd0;
            op_off      <= 2'd0;
            op_rd       <= 5'd0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            wb_valid    <= 1'b0;
            wb_rd_addr  <= 5'd0;
            wb_reg_wen  <= 1'b0;
            wb_data     <= 32'h0;
            wb_exc      <= EXC_NONE;
        end else begin
            if (accept) begin
                op_write    <= ex_access_type[2];
                op_sign     <= ex_sign_ext;
                op_wen      <= ex_reg_wen;
                op_size     <= ex_size;
                op_off      <= ex_addr[1:0];
                op_rd       <= ex_rd_addr;
                bus_we_q    <= ex_access_type[2];
                bus_addr_q  <= {ex_addr[31:2], 2'b00};
                bus_be_q    <= st_be;
                bus_wdata_q <= st_wdata;
            end else if (leave_bus) begin
                bus_we_q    <= 1'b0;
                bus_addr_q  <= 32'h0;
                bus_be_q    <= 4'b0000;
                bus_wdata_q <= 32'h0;
            end
            wb_valid   <= wb_valid_nxt;
            wb_rd_addr <= wb_rd_addr_nxt;
            wb_reg_wen <= wb_reg_wen_nxt;
            wb_data    <= wb_data_nxt;
            wb_exc     <= wb_exc_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 3 time units after the rising edge, well before the next one.

module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ex_valid = 1'b0;
    access_type_e ex_access_type = ACC_NONE;
    logic         ex_sign_ext = 1'b0;
    logic [31:0]  ex_addr = 32'h0;
    logic [31:0]  ex_wdata = 32'h0;
    logic [4:0]   ex_rd_addr = 5'd0;
    logic         ex_reg_wen = 1'b0;
    logic         flush = 1'b0;
    logic         mem_stall;
    logic         wb_valid;
    logic [4:0]   wb_rd_addr;
    logic         wb_reg_wen;
    logic [31:0]  wb_data;
    logic [1:0]   wb_exc;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_access_type (ex_access_type),
        .ex_sign_ext    (ex_sign_ext),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .ex_rd_addr     (ex_rd_addr),
        .ex_reg_wen     (ex_reg_wen),
        .flush          (flush),
        .mem_stall      (mem_stall),
        .bus            (bus_if.master),
        .wb_valid       (wb_valid),
        .wb_rd_addr     (wb_rd_addr),
        .wb_reg_wen     (wb_reg_wen),
        .wb_data        (wb_data),
        .wb_exc         (wb_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the drive point of the next cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input access_type_e t, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic sign, input logic [4:0] rd,
                            input logic wen);
        ex_valid       = v;
        ex_access_type = t;
        ex_addr        = addr;
        ex_wdata       = wdata;
        ex_sign_ext    = sign;
        ex_rd_addr     = rd;
        ex_reg_wen     = wen;
    endtask

    // One aligned access: accepted at T, bus_ready at T+k, retired at T+k+1.
    task automatic run_access(input string tag, input access_type_e t, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic sign, input logic [4:0] rd,
                              input logic [31:0] rdata, input int k,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                              input logic exp_wen);
        next_cycle();
        drive_ex(1'b1, t, addr, wdata, sign, rd, 1'b1);
        #2;
        check({tag, " accept stall"}, 32'(mem_stall), 32'd1);
        check({tag, " accept no req"}, 32'(bus_if.req), 32'd0);
        for (int i = 1; i <= k; i++) begin
            next_cycle();
            if (i == k) begin
                bus_if.ready = 1'b1;
                bus_if.rdata = rdata;
            end
            #2;
            check({tag, " req"}, 32'(bus_if.req), 32'd1);
            check({tag, " addr"}, bus_if.addr, exp_addr);
            check({tag, " be"}, 32'(bus_if.be), 32'(exp_be));
            check({tag, " we"}, 32'(bus_if.we), 32'(t[2]));
            if (t[2]) check({tag, " wdata"}, bus_if.wdata, exp_wdata);
            check({tag, " stall"}, 32'(mem_stall), (i == k) ? 32'd0 : 32'd1);
        end
        next_cycle();
        bus_if.ready = 1'b0;
        bus_if.rdata = 32'h0;
        ex_valid     = 1'b0;
        #2;
        check({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, " wb_reg_wen"}, 32'(wb_reg_wen), 32'(exp_wen));
        check({tag, " wb_rd"}, 32'(wb_rd_addr), 32'(rd));
        check({tag, " wb_exc"}, 32'(wb_exc), 32'd0);
        if (!t[2]) check({tag, " wb_data"}, wb_data, exp_data);
        check({tag, " req dropped"}, 32'(bus_if.req), 32'd0);
    endtask

    initial begin
        int req_cycles;
        bit seen_drop;
        bit retired;

        bus_if.ready = 1'b0;
        bus_if.rdata = 32'h0;

        // Reset state.
        #7;
        check("rst req", 32'(bus_if.req), 32'd0);
        check("rst stall", 32'(mem_stall), 32'd0);
        check("rst wb_valid", 32'(wb_valid), 32'd0);
        check("rst wb_data", wb_data, 32'h0);
        check("rst wb_exc", 32'(wb_exc), 32'd0);
        check("rst bus_addr", bus_if.addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: sign-extended byte load from lane 3, ready after 3 cycles.
        run_access("rd_byte", ACC_READ_BYTE, 32'h0000_1003, 32'h0, 1'b1, 5'd5,
                   32'h80FF_0000, 3, 32'h0000_1000, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1);

        // 2: half store to upper lanes, ready immediately.
        run_access("wr_half", ACC_WRITE_HALF, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 5'd6,
                   32'h0, 1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);

        // Extra lane coverage: byte store to lane 1, zero- and sign-extended half loads.
        run_access("wr_byte", ACC_WRITE_BYTE, 32'h0000_0041, 32'h0000_005A, 1'b0, 5'd3,
                   32'h0, 2, 32'h0000_0040, 4'b0010, 32'h5A5A_5A5A, 32'h0, 1'b0);
        run_access("rd_half_z", ACC_READ_HALF, 32'h0000_3002, 32'h0, 1'b0, 5'd8,
                   32'h8001_1234, 1, 32'h0000_3000, 4'b0000, 32'h0, 32'h0000_8001, 1'b1);
        run_access("rd_half_s", ACC_READ_HALF, 32'h0000_3002, 32'h0, 1'b1, 5'd9,
                   32'h8001_1234, 2, 32'h0000_3000, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b1);
        run_access("rd_word", ACC_READ_WORD, 32'h0000_0010, 32'h0, 1'b0, 5'd0,
                   32'hDEAD_BEEF, 1, 32'h0000_0010, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1);

        // 3: misaligned word load.
        next_cycle();
        drive_ex(1'b1, ACC_READ_WORD, 32'h0000_0006, 32'h0, 1'b0, 5'd4, 1'b1);
        #2;
        check("misal no req", 32'(bus_if.req), 32'd0);
        check("misal no stall", 32'(mem_stall), 32'd0);
        next_cycle();
        ex_valid = 1'b0;
        #2;
        check("misal wb_valid", 32'(wb_valid), 32'd1);
        check("misal wb_exc", 32'(wb_exc), 32'd1);
        check("misal wb_reg_wen", 32'(wb_reg_wen), 32'd0);
        check("misal req", 32'(bus_if.req), 32'd0);

        // 4: bus never answers; TIMEOUT=4.
        next_cycle();
        drive_ex(1'b1, ACC_READ_WORD, 32'h0000_0100, 32'h0, 1'b0, 5'd2, 1'b1);
        #2;
        check("to accept stall", 32'(mem_stall), 32'd1);
        req_cycles = 0;
        seen_drop  = 1'b0;
        retired    = 1'b0;
        for (int c = 0; c < 12 && !retired; c++) begin
            next_cycle();
            ex_valid = 1'b0;
            #2;
            if (wb_valid) begin
                retired = 1'b1;
            end else if (bus_if.req) begin
                req_cycles++;
            end else if (!seen_drop) begin
                seen_drop = 1'b1;
                check("to stall released", 32'(mem_stall), 32'd0);
            end
        end
        check("to req cycles", 32'(req_cycles), 32'd4);
        check("to retired", 32'(retired), 32'd1);
        check("to wb_exc", 32'(wb_exc), 32'd2);
        check("to wb_reg_wen", 32'(wb_reg_wen), 32'd0);
        check("to req low", 32'(bus_if.req), 32'd0);

        // 5: non-memory op, then a flushed slot.
        next_cycle();
        drive_ex(1'b1, ACC_NONE, 32'h0000_0055, 32'h0, 1'b0, 5'd7, 1'b1);
        #2;
        check("alu no stall", 32'(mem_stall), 32'd0);
        next_cycle();
        drive_ex(1'b1, ACC_NONE, 32'h0000_0099, 32'h0, 1'b0, 5'd9, 1'b1);
        flush = 1'b1;
        #2;
        check("alu wb_valid", 32'(wb_valid), 32'd1);
        check("alu wb_data", wb_data, 32'h0000_0055);
        check("alu wb_rd", 32'(wb_rd_addr), 32'd7);
        check("alu wb_reg_wen", 32'(wb_reg_wen), 32'd1);
        next_cycle();
        flush    = 1'b0;
        ex_valid = 1'b0;
        #2;
        check("flush bubble", 32'(wb_valid), 32'd0);

        // 6: reset in the middle of a bus transaction.
        next_cycle();
        drive_ex(1'b1, ACC_READ_WORD, 32'h0000_0200, 32'h0, 1'b0, 5'd1, 1'b1);
        next_cycle();
        ex_valid = 1'b0;
        #1;
        check("mid req before rst", 32'(bus_if.req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst req", 32'(bus_if.req), 32'd0);
        check("mid rst stall", 32'(mem_stall), 32'd0);
        check("mid rst wb_valid", 32'(wb_valid), 32'd0);
        check("mid rst bus_addr", bus_if.addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        #2;
        check("post rst idle req", 32'(bus_if.req), 32'd0);
        check("post rst wb_valid", 32'(wb_valid), 32'd0);
        run_access("post_rst", ACC_READ_BYTE, 32'h0000_0301, 32'h0, 1'b0, 5'd12,
                   32'h0000_C300, 1, 32'h0000_0300, 4'b0000, 32'h0, 32'h0000_00C3, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
